// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences decimated sample writes into the shared RAMqueue
// write port, tracks pre-trigger fill, arms the trigger and counts the
// post-trigger samples. On completion it pulses set_capture_done, leaving
// waddr pointing at the oldest sample for read-out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for capture_en with capture_done clear
// CAPTURE | pre-trigger fill; trigger accepted once armed
// POST    | writing trig_pos samples after the accepted trigger
// DONE    | single cycle; pulses set_capture_done, then back to IDLE
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  input  logic          capture_done,
  input  logic          triggered,
  input  logic [3:0]    decimator,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          capturing,
  output logic          set_capture_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);
  localparam logic [AW-1:0] FULL_CNT  = AW'(ENTRIES);
  localparam logic [AW:0]   ENTRIES_W = (AW+1)'(ENTRIES);

  state_t        state_q, state_d;
  logic [15:0]   dec_cnt_q, dec_cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] smpl_cnt_q, smpl_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          armed_q, armed_d;

  logic [15:0]   dec_max;
  logic [AW-1:0] tp;
  logic [AW:0]   arm_thr;
  logic [AW:0]   fill_nx;
  logic          active;
  logic          smpl_en;
  logic          we_nx;

  assign dec_max = 16'((17'd1 << decimator) - 17'd1);
  assign tp      = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
  assign arm_thr = ENTRIES_W - {1'b0, tp};
  assign active  = (state_q == S_CAPTURE) || (state_q == S_POST);
  assign smpl_en = (dec_cnt_q == dec_max);

  assign we               = active & smpl_en;
  assign waddr            = waddr_q;
  assign armed            = armed_q;
  assign capturing        = active;
  assign set_capture_done = (state_q == S_DONE);

  // Next-state, counter and address update logic.
  always_comb begin
    state_d    = state_q;
    dec_cnt_d  = '0;
    waddr_d    = waddr_q;
    smpl_cnt_d = smpl_cnt_q;
    post_cnt_d = post_cnt_q;

    if (active) begin
      dec_cnt_d = smpl_en ? 16'd0 : dec_cnt_q + 16'd1;
      if (we) waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + AW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (capture_en && !capture_done) begin
          state_d    = S_CAPTURE;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          post_cnt_d = '0;
          dec_cnt_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (we && (smpl_cnt_q != FULL_CNT)) smpl_cnt_d = smpl_cnt_q + AW'(1);
        if (!capture_en)                    state_d = S_IDLE;
        else if (triggered && armed_q)      state_d = (tp == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (we) post_cnt_d = post_cnt_q + AW'(1);
        if (!capture_en)                    state_d = S_IDLE;
        else if (we && (post_cnt_d >= tp))  state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // armed looks one cycle ahead: it is visible during the cycle whose
    // write completes the pre-trigger fill, so a trigger accepted in that
    // cycle leaves exactly ENTRIES samples in the buffer.
    we_nx   = (dec_cnt_d == dec_max);
    fill_nx = {1'b0, smpl_cnt_d} + {{AW{1'b0}}, we_nx};
    case (state_d)
      S_CAPTURE: armed_d = (fill_nx >= arm_thr);
      S_POST:    armed_d = armed_q;
      default:   armed_d = 1'b0;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dec_cnt_q  <= '0;
      waddr_q    <= '0;
      smpl_cnt_q <= '0;
      post_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_cnt_q  <= dec_cnt_d;
      waddr_q    <= waddr_d;
      smpl_cnt_q <= smpl_cnt_d;
      post_cnt_q <= post_cnt_d;
      armed_q    <= armed_d;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl: directed scenarios plus randomized trials,
// checked cycle by cycle against an arithmetic model of the capture timeline.
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int AW      = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic          capture_done;
  logic          triggered;
  logic [3:0]    decimator;
  logic [AW-1:0] trig_pos;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          capturing;
  logic          set_capture_done;

  int checks = 0;
  int errors = 0;

  capture_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .capture_en       (capture_en),
    .capture_done     (capture_done),
    .triggered        (triggered),
    .decimator        (decimator),
    .trig_pos         (trig_pos),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .capturing        (capturing),
    .set_capture_done (set_capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int exp_addr);
    chk({tag, " we"}, 32'(we), 0);
    chk({tag, " capturing"}, 32'(capturing), 0);
    chk({tag, " armed"}, 32'(armed), 0);
    chk({tag, " set_done"}, 32'(set_capture_done), 0);
    chk({tag, " waddr"}, 32'(waddr), 32'(exp_addr));
  endtask

  // One capture. Cycle k=0 is the first CAPTURE cycle. Writes land on cycles
  // P-1, 2P-1, ...; armed is first visible on the cycle of write number
  // ENTRIES-tp. level: triggered high from cycle tc on; otherwise a pulse at
  // tc (must be >= arming cycle). early: extra ignored pulse (-1 none).
  // abort_c: cycle with capture_en low (-1 none).
  task automatic run_trial(input string tag, input int dec, input int tp_raw,
                           input bit level, input int tc, input int early,
                           input int abort_c);
    int p, tp, arm_c, c, pre, end_c, stop, final_addr;
    bit ab;
    p     = 1 << dec;
    tp    = (tp_raw > ENTRIES - 1) ? ENTRIES - 1 : tp_raw;
    arm_c = (ENTRIES - tp) * p - 1;
    c     = level ? ((tc > arm_c) ? tc : arm_c) : tc;
    pre   = (c + 1) / p;
    end_c = (tp == 0) ? c : (pre + tp) * p - 1;
    ab    = (abort_c >= 0) && (abort_c <= end_c);
    stop  = ab ? abort_c : end_c;
    final_addr = ((stop + 1) / p) % ENTRIES;

    @(negedge clk);
    decimator    = 4'(dec);
    trig_pos     = AW'(tp_raw);
    triggered    = 1'b0;
    capture_done = 1'b0;
    capture_en   = 1'b1;
    for (int k = 0; k <= stop + 1; k++) begin
      @(negedge clk);
      chk({tag, " we"}, 32'(we), 32'((k <= stop) && ((k + 1) % p == 0)));
      chk({tag, " waddr"}, 32'(waddr), 32'((k / p) % ENTRIES));
      chk({tag, " capturing"}, 32'(capturing), 32'(k <= stop));
      chk({tag, " armed"}, 32'(armed), 32'((k <= stop) && (k >= arm_c)));
      chk({tag, " set_done"}, 32'(set_capture_done), 32'(!ab && (k == stop + 1)));
      if (set_capture_done) capture_done = 1'b1;
      if (ab && k == abort_c) capture_en = 1'b0;
      if (k > stop)   triggered = 1'b0;
      else if (level) triggered = (k >= tc);
      else            triggered = (k == tc) || (k == early);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_idle({tag, " idle"}, final_addr);
      chk({tag, " done_flag"}, 32'(capture_done), 32'(!ab));
    end
    capture_en   = 1'b0;
    capture_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    capture_en   = 1'b0;
    capture_done = 1'b0;
    triggered    = 1'b0;
    decimator    = '0;
    trig_pos     = '0;
    #12;
    chk_idle("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 0);

    // held trigger, tp=100: 284 pre + 100 post, waddr ends at 0
    run_trial("t1_dec0_tp100", 0, 100, 1'b1, 0, -1, -1);
    // decimate by 4, tp=10: armed at write 374
    run_trial("t2_dec2_tp10", 2, 10, 1'b1, 0, -1, -1);
    // tp=0, trigger on the cycle of write 500: waddr = 116
    run_trial("t3_tp0", 0, 0, 1'b0, 499, -1, -1);
    // early pulse at write 50 ignored, second at write 400 accepted
    run_trial("t4_early", 0, 100, 1'b0, 399, 49, -1);
    // abort during POST after 20 post writes
    run_trial("t5_abort", 0, 100, 1'b1, 0, -1, 303);
    // trig_pos above ENTRIES-1 is clamped
    run_trial("t_clamp", 1, 500, 1'b1, 0, -1, -1);

    // reset mid-POST, then restart blocked by capture_done
    @(negedge clk);
    decimator  = 4'd0;
    trig_pos   = AW'(100);
    triggered  = 1'b1;
    capture_en = 1'b1;
    repeat (300) @(negedge clk);
    chk("t6 in_post capturing", 32'(capturing), 1);
    chk("t6 in_post armed", 32'(armed), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("t6 async_reset", 0);
    @(negedge clk);
    capture_done = 1'b1;
    capture_en   = 1'b1;
    rst_n        = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_idle("t6 blocked", 0);
    end
    capture_done = 1'b0;
    @(negedge clk);
    chk("t6 restart capturing", 32'(capturing), 1);
    chk("t6 restart we", 32'(we), 1);
    chk("t6 restart waddr", 32'(waddr), 0);
    capture_en = 1'b0;
    triggered  = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("t6 abort", 1);

    // randomized trials
    for (int t = 0; t < 8; t++) begin
      int dec, tpr, tpc, arm, tc, early, ab, endc, pre;
      bit level;
      dec   = $urandom_range(0, 2);
      tpr   = $urandom_range(0, 511);
      level = 1'($urandom_range(0, 1));
      tpc   = (tpr > ENTRIES - 1) ? ENTRIES - 1 : tpr;
      arm   = (ENTRIES - tpc) * (1 << dec) - 1;
      early = -1;
      if (level) begin
        tc = $urandom_range(0, arm + 200);
      end else begin
        tc = arm + $urandom_range(0, 300);
        if (arm > 0) early = $urandom_range(0, arm - 1);
      end
      ab = -1;
      if ($urandom_range(0, 2) == 0) begin
        int cc;
        cc   = (level && tc < arm) ? arm : tc;
        pre  = (cc + 1) >> dec;
        endc = (tpc == 0) ? cc : ((pre + tpc) << dec) - 1;
        if (endc >= 1) ab = $urandom_range(0, endc - 1);
      end
      run_trial($sformatf("rnd%0d", t), dec, tpr, level, tc, early, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
